capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Single-clock trigger/capture controller that writes a continuous sample stream into the write port of the dual-clock capture RAM. It keeps a circular pre-trigger history, waits for a qualified trigger, records a programmable number of post-trigger samples, then freezes and reports the trigger and oldest-sample addresses. Readout software on the RAM's read clock uses those addresses to unwrap the buffer.

## Interface
Parameters:
- DATAWIDTH, 18, sample width; matches the RAM data width
- ADDRWIDTH, 10, RAM address width; depth D = 2^ADDRWIDTH

Ports:
- clk  in  1  sample clock; also drives the RAM write clock
- reset_l  in  1  synchronous, active-low reset
- arm  in  1  single-cycle pulse; starts a capture
- abort  in  1  single-cycle pulse; returns to IDLE from any state
- pretrig  in  ADDRWIDTH  minimum samples written since arm before a trigger is accepted
- posttrig  in  ADDRWIDTH  samples written after the trigger sample
- in_data  in  DATAWIDTH  sample
- in_valid  in  1  sample qualifier
- trig  in  1  trigger, sampled only when in_valid=1
- wr_addr  out  ADDRWIDTH  RAM write address
- wr_data  out  DATAWIDTH  RAM write data
- we  out  1  RAM write enable
- busy  out  1  high in ARMED or POST
- done  out  1  high in DONE
- trig_addr  out  ADDRWIDTH  address of the trigger sample
- start_addr  out  ADDRWIDTH  address of the oldest valid sample
- wrapped  out  1  pointer has wrapped at least once since arm

## Operation
- States: IDLE, ARMED, POST, DONE. Reset enters IDLE.
- Reset values: all outputs 0. Internal write pointer ptr = 0, fill = 0, post counter = 0.
- IDLE: no writes. arm moves to ARMED and clears ptr, fill and wrapped.
- ARMED, each in_valid cycle:
  - Write in_data at ptr, then increment ptr modulo D.
  - fill increments, saturating at D-1.
  - When ptr goes from D-1 to 0, set wrapped.
- Trigger accepted when in_valid && trig && fill >= pretrig, with fill taken before the increment.
  - The trigger sample is written normally and trig_addr is set to ptr.
  - If posttrig = 0, go to DONE; otherwise load the counter with posttrig and go to POST.
- trig on a cycle with in_valid=0 is ignored.
- POST, each in_valid cycle: write, increment ptr, decrement the counter. The write that takes the counter from 1 to 0 moves the state to DONE. trig is ignored.
- DONE:
  - No writes.
  - Capture outputs hold.
  - start_addr = wrapped ? last_ptr+1 (mod D) : 0, where last_ptr is the address of the final write.
  - arm restarts a capture, as from IDLE.
- abort has priority over every other event, including a simultaneous arm or trigger. It goes to IDLE, suppresses that cycle's write, and leaves trig_addr and start_addr unchanged.
- arm while busy is ignored.
- No overwrite protection. Software guarantees pretrig + posttrig + 1 <= D; otherwise the oldest pre-trigger samples are overwritten and start_addr still points to the oldest surviving sample.
- pretrig and posttrig are sampled on use and must be held stable while busy.

## Timing
- All outputs are registered.
- Sample at edge n with in_valid=1 produces we=1, wr_addr and wr_data during cycle n+1, committed to the RAM at edge n+1.
- busy rises in the cycle after arm is sampled and falls in the same cycle done rises.
- done rises in the cycle after the final we=1. trig_addr, start_addr and wrapped are valid when done=1.
- trig_addr updates in the same cycle as the trigger sample's we.
- Back-to-back in_valid sustains one write per clock. Gaps in in_valid stall all counters.
- reset_l low mid-capture: IDLE at the next edge, we=0 from that cycle, no partial state retained.

## Test plan
All scenarios use ADDRWIDTH=4 (D=16).
- **Basic capture:** pretrig=4, posttrig=3, continuous samples 0,1,2,…; trig on sample 6. Expect writes at addrs 0..9, trig_addr=6, wrapped=0, start_addr=0, done one cycle after the write to addr 9.
- **Early trigger rejected:** pretrig=4; trig on samples 2 and 5. Expect the trigger accepted at sample 5 (fill=5 >= 4) and trig_addr=5; trig on sample 2 ignored.
- **Wrap-around:** pretrig=0, posttrig=2, trig on sample 20. Expect trig_addr=4, last write at addr 6, wrapped=1, start_addr=7; addr 15 holds sample 15 and addr 0 holds sample 16.
- **posttrig=0 with in_valid gaps:** posttrig=0, in_valid toggling 1,0,1,0, trig on the third valid sample. Expect exactly 3 writes at addrs 0..2, trig_addr=2, done the cycle after the last write, no write on invalid cycles.
- **Abort priority:** abort and a qualified trig in the same cycle. Expect no write that cycle, IDLE next cycle, busy=0, done=0, trig_addr unchanged.
- **Reset mid-POST:** reset_l=0 for one edge. Expect we=0, busy=0, all outputs 0; a subsequent arm restarts at addr 0.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// Capture controller bus: control/trigger inputs, RAM write port and capture status.
interface capture_ctrl_if #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 10
);
  logic                 arm;
  logic                 abort;
  logic [ADDRWIDTH-1:0] pretrig;
  logic [ADDRWIDTH-1:0] posttrig;
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 trig;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [DATAWIDTH-1:0] wr_data;
  logic                 we;
  logic                 busy;
  logic                 done;
  logic [ADDRWIDTH-1:0] trig_addr;
  logic [ADDRWIDTH-1:0] start_addr;
  logic                 wrapped;

  modport master (
    output arm, abort, pretrig, posttrig, in_data, in_valid, trig,
    input  wr_addr, wr_data, we, busy, done, trig_addr, start_addr, wrapped
  );

  modport slave (
    input  arm, abort, pretrig, posttrig, in_data, in_valid, trig,
    output wr_addr, wr_data, we, busy, done, trig_addr, start_addr, wrapped
  );
endinterface

// File: rtl/capture_ctrl.sv
// Trigger/capture controller: circular pre-trigger history, qualified trigger, N post samples.
// One-cycle registered write path; done rises the cycle after the final write, no backpressure.
module capture_ctrl #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 10
) (
  input  logic           i_clk,
  input  logic           i_reset_l,
  capture_ctrl_if.slave  bus
);
  localparam logic [ADDRWIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t               r_state;
  logic [ADDRWIDTH-1:0] r_ptr;
  logic [ADDRWIDTH-1:0] r_fill;
  logic [ADDRWIDTH-1:0] r_cnt;
  logic [ADDRWIDTH-1:0] r_wr_addr;
  logic [DATAWIDTH-1:0] r_wr_data;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_done;
  logic [ADDRWIDTH-1:0] r_trig_addr;
  logic [ADDRWIDTH-1:0] r_start_addr;
  logic                 r_wrapped;

  logic w_write;
  logic w_trig_ok;
  logic w_start;

  assign w_write   = bus.in_valid && (r_state == ARMED || r_state == POST);
  assign w_trig_ok = bus.in_valid && bus.trig && (r_fill >= bus.pretrig);
  // DONE is entered one cycle before done is shown so the final write drains first.
  assign w_start   = bus.arm && (r_state == IDLE || (r_state == DONE && r_done));

  always_ff @(posedge i_clk) begin
    if (!i_reset_l) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_fill       <= '0;
      r_cnt        <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_wrapped    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (bus.abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        if (w_write) begin
          r_we      <= 1'b1;
          r_wr_addr <= r_ptr;
          r_wr_data <= bus.in_data;
          r_ptr     <= r_ptr + 1'b1;
          if (r_ptr == ADDR_MAX) r_wrapped <= 1'b1;
        end
        if (w_start) begin
          r_state   <= ARMED;
          r_ptr     <= '0;
          r_fill    <= '0;
          r_wrapped <= 1'b0;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
        end
        case (r_state)
          ARMED: if (bus.in_valid) begin
            if (r_fill != ADDR_MAX) r_fill <= r_fill + 1'b1;
            if (w_trig_ok) begin
              r_trig_addr <= r_ptr;
              if (bus.posttrig == '0) begin
                r_state <= DONE;
              end else begin
                r_cnt   <= bus.posttrig;
                r_state <= POST;
              end
            end
          end
          POST: if (bus.in_valid) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == ADDRWIDTH'(1)) r_state <= DONE;
          end
          DONE: if (!r_done) begin
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_start_addr <= r_wrapped ? r_ptr : '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.we         = r_we;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.trig_addr  = r_trig_addr;
  assign bus.start_addr = r_start_addr;
  assign bus.wrapped    = r_wrapped;
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl with D=16: sample-count model compared every cycle plus literal checks.
module tb_capture_ctrl;
  localparam int DW = 18;
  localparam int AW = 4;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  capture_ctrl_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();
  capture_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .i_clk(clk), .i_reset_l(reset_l), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: capture described by the number of samples written since arm.
  // mode 0 idle, 1 capturing, 2 final write draining, 3 done shown
  int  mode = 0;
  int  n = 0;
  int  fin_n = 0;
  bit  have_trig = 0;
  bit  m_on = 0;
  bit  e_we = 0, e_busy = 0, e_done = 0, e_wrap = 0;
  int  e_addr = 0, e_data = 0, e_trig = 0, e_start = 0;

  always @(posedge clk) begin
    e_we = 0;
    if (!reset_l) begin
      m_on = 1; mode = 0; n = 0; have_trig = 0;
      e_busy = 0; e_done = 0; e_wrap = 0;
      e_addr = 0; e_data = 0; e_trig = 0; e_start = 0;
    end else if (bus.abort) begin
      mode = 0; e_busy = 0; e_done = 0;
    end else if (mode == 0 || mode == 3) begin
      if (bus.arm) begin
        mode = 1; n = 0; have_trig = 0; e_wrap = 0; e_busy = 1; e_done = 0;
      end
    end else if (mode == 1) begin
      if (bus.in_valid) begin
        e_we = 1; e_addr = n % D; e_data = int'(bus.in_data);
        if (!have_trig && bus.trig && n >= int'(bus.pretrig)) begin
          have_trig = 1; e_trig = n % D; fin_n = n + 1 + int'(bus.posttrig);
        end
        n++;
        e_wrap = (n >= D);
        if (have_trig && n == fin_n) mode = 2;
      end
    end else begin
      mode = 3; e_done = 1; e_busy = 0;
      e_start = (n >= D) ? n % D : 0;
    end
  end

  logic [DW-1:0] mem [D];
  int wcount = 0;

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      mem[bus.wr_addr] = bus.wr_data;
      wcount++;
    end
    if (m_on) begin
      chk("we", 32'(bus.we), 32'(e_we));
      if (e_we) begin
        chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e_data));
      end
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("wrapped", 32'(bus.wrapped), 32'(e_wrap));
      chk("trig_addr", 32'(bus.trig_addr), 32'(e_trig));
      chk("start_addr", 32'(bus.start_addr), 32'(e_start));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.arm = 0;
    bus.abort = 0;
  endtask

  task automatic do_arm(input int pre, input int post);
    bus.pretrig = AW'(pre);
    bus.posttrig = AW'(post);
    bus.in_valid = 0; bus.trig = 0;
    bus.arm = 1;
    tick();
  endtask

  task automatic sample(input bit v, input bit t, input int d);
    bus.in_valid = v; bus.trig = t; bus.in_data = DW'(d);
    tick();
  endtask

  int w0;

  initial begin
    bus.arm = 0; bus.abort = 0; bus.pretrig = '0; bus.posttrig = '0;
    bus.in_data = '0; bus.in_valid = 0; bus.trig = 0;
    tick(); tick();
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_trig_addr", 32'(bus.trig_addr), 0);
    reset_l = 1;
    tick();

    // Basic capture
    do_arm(4, 3);
    for (int i = 0; i < 10; i++) sample(1, i == 6, i);
    sample(0, 0, 0);
    chk("basic_done", 32'(bus.done), 1);
    chk("basic_trig_addr", 32'(bus.trig_addr), 6);
    chk("basic_wrapped", 32'(bus.wrapped), 0);
    chk("basic_start", 32'(bus.start_addr), 0);
    chk("basic_mem9", 32'(mem[9]), 9);

    // Early trigger rejected
    do_arm(4, 1);
    for (int i = 0; i < 7; i++) sample(1, i == 2 || i == 5, 100 + i);
    sample(0, 0, 0);
    chk("early_trig_addr", 32'(bus.trig_addr), 5);
    chk("early_mem2", 32'(mem[2]), 102);

    // Wrap-around
    do_arm(0, 2);
    for (int i = 0; i < 23; i++) sample(1, i == 20, i);
    sample(0, 0, 0);
    chk("wrap_done", 32'(bus.done), 1);
    chk("wrap_trig_addr", 32'(bus.trig_addr), 4);
    chk("wrap_wrapped", 32'(bus.wrapped), 1);
    chk("wrap_start", 32'(bus.start_addr), 7);
    chk("wrap_mem15", 32'(mem[15]), 15);
    chk("wrap_mem0", 32'(mem[0]), 16);
    chk("wrap_mem6", 32'(mem[6]), 22);

    // posttrig=0 with gaps
    do_arm(0, 0);
    w0 = wcount;
    sample(1, 0, 200); sample(0, 0, 0);
    sample(1, 0, 201); sample(0, 1, 0);
    sample(1, 1, 202);
    sample(0, 0, 0);
    chk("gap_done", 32'(bus.done), 1);
    chk("gap_writes", 32'(wcount - w0), 3);
    chk("gap_trig_addr", 32'(bus.trig_addr), 2);
    chk("gap_mem2", 32'(mem[2]), 202);

    // Abort with a qualified trigger in the same cycle
    do_arm(0, 3);
    for (int i = 0; i < 3; i++) sample(1, 0, 50 + i);
    bus.abort = 1;
    sample(1, 1, 99);
    chk("abort_we", 32'(bus.we), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_trig_addr", 32'(bus.trig_addr), 2);
    sample(0, 0, 0);

    // Reset during POST
    do_arm(0, 5);
    for (int i = 0; i < 4; i++) sample(1, i == 1, 60 + i);
    reset_l = 0;
    sample(1, 0, 70);
    chk("rstpost_we", 32'(bus.we), 0);
    chk("rstpost_busy", 32'(bus.busy), 0);
    chk("rstpost_wrapped", 32'(bus.wrapped), 0);
    chk("rstpost_trig_addr", 32'(bus.trig_addr), 0);
    chk("rstpost_wr_addr", 32'(bus.wr_addr), 0);
    reset_l = 1;
    do_arm(0, 1);
    sample(1, 0, 300);
    chk("restart_we", 32'(bus.we), 1);
    chk("restart_addr", 32'(bus.wr_addr), 0);
    chk("restart_data", 32'(bus.wr_data), 300);
    sample(0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
